fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_sat_counter.sv | 23 ++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared ISA definitions: word widths, reset/halt encodings, opcodes and fetch FSM states.
package fetch_unit_pkg;

    localparam int unsigned XLEN  = 8;
    localparam int unsigned CNT_W = 16;

    localparam logic [XLEN-1:0] ISA_RESET_PC  = 8'h00;
    localparam logic [XLEN-1:0] ISA_HALT_WORD = 8'hFF;

    // Major opcode encodings (upper nibble of the instruction word)
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h1;
    localparam logic [3:0] OP_STORE  = 4'h2;
    localparam logic [3:0] OP_ADD    = 4'h3;
    localparam logic [3:0] OP_SUB    = 4'h4;
    localparam logic [3:0] OP_BRANCH = 4'hA;
    localparam logic [3:0] OP_SYS    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Next sequential fetch address; wraps 0xFF -> 0x00
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return XLEN'(pc + XLEN'(1));
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: ROM address/data, decode handshake and execute redirect.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [XLEN-1:0] address_o;
    logic [XLEN-1:0] instruction_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
    logic            valid_o;
    logic            ready_i;
    logic            branch_taken_i;
    logic [XLEN-1:0] branch_target_i;

    modport master (
        output address_o, instr_o, pc_o, valid_o,
        input  instruction_i, ready_i, branch_taken_i, branch_target_i
    );

    modport slave (
        input  address_o, instr_o, pc_o, valid_o,
        output instruction_i, ready_i, branch_taken_i, branch_target_i
    );

endinterface

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks a combinational ROM, buffers one word for decode,
// handles decode back-pressure, execute redirects and halt-word detection.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = ISA_RESET_PC,
    parameter logic [XLEN-1:0] HALT_WORD = ISA_HALT_WORD
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    output logic               halted_o,
    output logic [CNT_W-1:0]   fetch_count_o,
    fetch_unit_if.master       bus
);

    fetch_state_e    state_q, state_next;
    logic [XLEN-1:0] pc_q, pc_next;
    logic [XLEN-1:0] instr_q, instr_next;
    logic [XLEN-1:0] pc_out_q, pc_out_next;
    logic            valid_q, valid_next;
    logic            halted_q;
    logic            cnt_inc, cnt_clr;
    logic            can_accept;
    logic            is_halt_word;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state and datapath update selection
    always_comb begin
        state_next   = state_q;
        pc_next      = pc_q;
        instr_next   = instr_q;
        pc_out_next  = pc_out_q;
        valid_next   = valid_q;
        cnt_inc      = 1'b0;
        cnt_clr      = 1'b0;
        can_accept   = !valid_q || bus.ready_i;
        is_halt_word = (bus.instruction_i == HALT_WORD);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pc_next    = RESET_PC;
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.branch_taken_i) begin
                    // Redirect beats stall, fetch and halt detection
                    pc_next    = bus.branch_target_i;
                    valid_next = 1'b0;
                end else if (can_accept) begin
                    if (is_halt_word) begin
                        valid_next = 1'b0;
                        state_next = ST_DRAIN;
                    end else begin
                        instr_next  = bus.instruction_i;
                        pc_out_next = pc_q;
                        valid_next  = 1'b1;
                        pc_next     = pc_inc(pc_q);
                        cnt_inc     = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (bus.branch_taken_i) begin
                    pc_next    = bus.branch_target_i;
                    valid_next = 1'b0;
                    state_next = ST_RUN;
                end else if (valid_q && bus.ready_i) begin
                    valid_next = 1'b0;
                end else if (!valid_q) begin
                    state_next = ST_HALT;
                end
            end

            ST_HALT: begin
                if (start_i) begin
                    pc_next    = RESET_PC;
                    cnt_clr    = 1'b1;
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // PC, decode buffer and halt flag registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_next;
            instr_q  <= instr_next;
            pc_out_q <= pc_out_next;
            valid_q  <= valid_next;
            halted_q <= (state_next == ST_HALT);
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_fetch_count (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (fetch_count_o)
    );

    assign bus.address_o = pc_q;
    assign bus.instr_o   = instr_q;
    assign bus.pc_o      = pc_out_q;
    assign bus.valid_o   = valid_q;
    assign halted_o      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: lab ROM, transaction-level reference model, directed scenarios.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [7:0] RST_PC = 8'h00;
    localparam logic [7:0] HALTW  = 8'hFF;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halted;
    logic [15:0] fetch_count;
    logic [7:0]  rom [256];

    fetch_unit_if bus_if ();

    assign bus_if.instruction_i = rom[bus_if.address_o];

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .HALT_WORD (HALTW)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .halted_o      (halted),
        .fetch_count_o (fetch_count),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one-deep decode buffer, next fetch address, run/halt flags
    ent_t       fifo_q[$];
    bit         m_idle     = 1'b1;
    bit         m_halted   = 1'b0;
    bit         m_fetching = 1'b0;
    logic [7:0] m_next     = RST_PC;
    int         m_count    = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            fifo_q.delete();
            m_idle     = 1'b1;
            m_halted   = 1'b0;
            m_fetching = 1'b0;
            m_next     = RST_PC;
            m_count    = 0;
        end else if (m_idle || m_halted) begin
            if (start) begin
                if (m_halted) m_count = 0;
                m_idle     = 1'b0;
                m_halted   = 1'b0;
                m_fetching = 1'b1;
                m_next     = RST_PC;
            end
        end else if (bus_if.branch_taken_i) begin
            fifo_q.delete();
            m_next     = bus_if.branch_target_i;
            m_fetching = 1'b1;
        end else begin
            if (fifo_q.size() != 0 && bus_if.ready_i) void'(fifo_q.pop_front());
            if (fifo_q.size() == 0) begin
                if (!m_fetching) begin
                    m_halted = 1'b1;
                end else if (rom[m_next] == HALTW) begin
                    m_fetching = 1'b0;
                end else begin
                    fifo_q.push_back('{pc: m_next, ins: rom[m_next]});
                    m_next = 8'(m_next + 8'd1);
                    if (m_count < 65535) m_count++;
                end
            end
        end
    end

    // Per-cycle comparison of DUT against the model
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("address", 32'(bus_if.address_o), 32'(m_next));
            check("valid", 32'(bus_if.valid_o), 32'(fifo_q.size() != 0));
            check("halted", 32'(halted), 32'(m_halted));
            check("fetch_count", 32'(fetch_count), 32'(m_count));
            if (fifo_q.size() != 0) begin
                check("pc_o", 32'(bus_if.pc_o), 32'(fifo_q[0].pc));
                check("instr_o", 32'(bus_if.instr_o), 32'(fifo_q[0].ins));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = HALTW;
        rom[8'h00] = 8'h11; rom[8'h01] = 8'h22; rom[8'h02] = 8'h33;
        rom[8'h03] = 8'h44; rom[8'h04] = 8'hA5;
        rom[8'h10] = 8'hB0;
        rom[8'h20] = 8'h30; rom[8'h21] = 8'h31; rom[8'h22] = 8'h32;
        rom[8'hFF] = 8'hC7;
        bus_if.ready_i         = 1'b1;
        bus_if.branch_taken_i  = 1'b0;
        bus_if.branch_target_i = 8'h00;

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick(1);
        check("rst_valid", 32'(bus_if.valid_o), 32'h0);
        check("rst_addr", 32'(bus_if.address_o), 32'h00);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);
        check("rst_instr", 32'(bus_if.instr_o), 32'h00);

        // Straight-line program then halt
        pulse_start();
        tick(1);
        check("s1_pc0", 32'(bus_if.pc_o), 32'h00);
        check("s1_ins0", 32'(bus_if.instr_o), 32'h11);
        for (int k = 1; k < 5; k++) begin
            tick(1);
            check("s1_pc_seq", 32'(bus_if.pc_o), 32'(k));
        end
        tick(1);
        check("s1_not_halted_yet", 32'(halted), 32'h0);
        tick(1);
        check("s1_halted", 32'(halted), 32'h1);
        check("s1_count", 32'(fetch_count), 32'd5);
        check("s1_model_count", 32'(m_count), 32'd5);

        // Decode stall at pc 0x02
        pulse_start();
        check("s2_count_clr", 32'(fetch_count), 32'h0);
        check("s2_unhalt", 32'(halted), 32'h0);
        tick(3);
        check("s2_pc2", 32'(bus_if.pc_o), 32'h02);
        bus_if.ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("s2_stall_pc", 32'(bus_if.pc_o), 32'h02);
            check("s2_stall_ins", 32'(bus_if.instr_o), 32'h33);
            check("s2_stall_addr", 32'(bus_if.address_o), 32'h03);
            check("s2_stall_valid", 32'(bus_if.valid_o), 32'h1);
        end
        bus_if.ready_i = 1'b1;
        tick(1);
        check("s2_next_pc", 32'(bus_if.pc_o), 32'h03);
        tick(3);
        check("s2_halted", 32'(halted), 32'h1);
        check("s2_count", 32'(fetch_count), 32'd5);

        // Branch concurrent with stall
        pulse_start();
        tick(2);
        check("s3_pc1", 32'(bus_if.pc_o), 32'h01);
        check("s3_count_pre", 32'(fetch_count), 32'd2);
        bus_if.ready_i         = 1'b0;
        bus_if.branch_taken_i  = 1'b1;
        bus_if.branch_target_i = 8'h20;
        tick(1);
        check("s3_flush_valid", 32'(bus_if.valid_o), 32'h0);
        check("s3_flush_addr", 32'(bus_if.address_o), 32'h20);
        check("s3_flush_count", 32'(fetch_count), 32'd2);
        bus_if.branch_taken_i = 1'b0;
        bus_if.ready_i        = 1'b1;
        tick(1);
        check("s3_target_pc", 32'(bus_if.pc_o), 32'h20);
        check("s3_target_ins", 32'(bus_if.instr_o), 32'h30);
        check("s3_count_post", 32'(fetch_count), 32'd3);
        tick(4);
        check("s3_halted", 32'(halted), 32'h1);
        check("s3_count", 32'(fetch_count), 32'd5);

        // Branch arrives during drain
        pulse_start();
        tick(5);
        check("s4_pc4", 32'(bus_if.pc_o), 32'h04);
        tick(1);
        check("s4_drain_valid", 32'(bus_if.valid_o), 32'h0);
        check("s4_drain_halted", 32'(halted), 32'h0);
        bus_if.branch_taken_i  = 1'b1;
        bus_if.branch_target_i = 8'h10;
        tick(1);
        check("s4_redir_halted", 32'(halted), 32'h0);
        check("s4_redir_addr", 32'(bus_if.address_o), 32'h10);
        bus_if.branch_taken_i = 1'b0;
        tick(1);
        check("s4_pc10", 32'(bus_if.pc_o), 32'h10);
        check("s4_ins10", 32'(bus_if.instr_o), 32'hB0);
        tick(2);
        check("s4_halted", 32'(halted), 32'h1);
        check("s4_count", 32'(fetch_count), 32'd6);

        // PC wrap from 0xFF
        pulse_start();
        tick(1);
        bus_if.branch_taken_i  = 1'b1;
        bus_if.branch_target_i = 8'hFF;
        tick(1);
        check("s5_addr_ff", 32'(bus_if.address_o), 32'hFF);
        bus_if.branch_taken_i = 1'b0;
        tick(1);
        check("s5_pc_ff", 32'(bus_if.pc_o), 32'hFF);
        check("s5_ins_ff", 32'(bus_if.instr_o), 32'hC7);
        check("s5_addr_wrap", 32'(bus_if.address_o), 32'h00);
        tick(1);
        check("s5_pc_wrap", 32'(bus_if.pc_o), 32'h00);
        tick(6);
        check("s5_halted", 32'(halted), 32'h1);
        check("s5_count", 32'(fetch_count), 32'd7);

        // Asynchronous reset mid-run
        pulse_start();
        tick(2);
        check("s6_pc1", 32'(bus_if.pc_o), 32'h01);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_valid", 32'(bus_if.valid_o), 32'h0);
        check("s6_rst_pc", 32'(bus_if.pc_o), 32'h00);
        check("s6_rst_ins", 32'(bus_if.instr_o), 32'h00);
        check("s6_rst_halted", 32'(halted), 32'h0);
        check("s6_rst_count", 32'(fetch_count), 32'h0);
        check("s6_rst_addr", 32'(bus_if.address_o), 32'h00);
        @(negedge clk);
        #3 rst_n = 1'b1;
        tick(3);
        check("s6_idle_valid", 32'(bus_if.valid_o), 32'h0);
        check("s6_idle_count", 32'(fetch_count), 32'h0);
        pulse_start();
        tick(1);
        check("s6_restart_pc", 32'(bus_if.pc_o), 32'h00);
        check("s6_restart_valid", 32'(bus_if.valid_o), 32'h1);
        tick(6);
        check("s6_halted", 32'(halted), 32'h1);
        check("s6_count", 32'(fetch_count), 32'd5);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
